rom_word_fetcher: RTL and testbench
===================================

# rom_word_fetcher

Initiator for the dual-port byte ROM (SimpleRom). It accepts 32-bit word fetch requests from the CPU front end and drives both ROM select ports to read two bytes per cycle. It assembles the four bytes big-endian into one word and returns it through a valid/ready response channel. Misaligned and out-of-range addresses are answered with an error response and never touch the ROM.

## Interface
Parameters:
- BUS_WIDTH, 8: ROM data width in bits; response word is 4*BUS_WIDTH.
- SELECT_WIDTH, 32: width of request address and ROM select ports.
- MEMORY_SIZE, 128: ROM size in bytes; used for the range check.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  fetch request present.
- req_addr  in  SELECT_WIDTH  byte address of the word.
- req_ready  out  1  fetcher can accept a request.
- rsp_valid  out  1  response present.
- rsp_data  out  4*BUS_WIDTH  fetched word, big-endian.
- rsp_err  out  1  request rejected (misaligned or out of range).
- rsp_ready  in  1  consumer accepts the response.
- mem_sel  out  SELECT_WIDTH  ROM port select (even byte of each pair).
- mem_sel_a  out  SELECT_WIDTH  ROM port A select (odd byte of each pair).
- mem_data  in  BUS_WIDTH  ROM data for mem_sel.
- mem_data_a  in  BUS_WIDTH  ROM data for mem_sel_a.

## Operation
- ROM contract: a select value registered at edge k produces valid mem_data during cycle k+1 (one-cycle latency). mem_sel and mem_sel_a are registered outputs.
- States: IDLE, SEL_LO, SEL_HI, CAP_HI, RESP.
- IDLE: req_ready=1. A handshake (req_valid&req_ready) latches req_addr.
  - Error if req_addr[1:0]!=0, or if {1'b0,req_addr}+4 > MEMORY_SIZE. The check uses SELECT_WIDTH+1 bits, so no wrap at the top of the address space. On error: rsp_err<=1, rsp_data<=0, go to RESP, mem_sel and mem_sel_a unchanged.
  - Otherwise: mem_sel<=addr, mem_sel_a<=addr+1, go to SEL_LO.
- SEL_LO: mem_sel<=addr+2, mem_sel_a<=addr+3. Go to SEL_HI.
- SEL_HI: rsp_data[31:24]<=mem_data, rsp_data[23:16]<=mem_data_a. Go to CAP_HI.
- CAP_HI: rsp_data[15:8]<=mem_data, rsp_data[7:0]<=mem_data_a, rsp_err<=0, rsp_valid<=1. Go to RESP.
- RESP: rsp_valid=1, with rsp_data and rsp_err held stable until rsp_valid&rsp_ready. Then rsp_valid<=0 and go to IDLE.
- req_ready is 0 in every state except IDLE. Only one request is in flight.
- Bit slices above are for BUS_WIDTH=8; in general, byte i occupies bits [(4-i)*BUS_WIDTH-1 -: BUS_WIDTH].

## Timing
- Reset: state=IDLE, rsp_valid=0, rsp_err=0, rsp_data=0, mem_sel=0, mem_sel_a=0. req_ready=0 while rst=1.
- Reset mid-operation: the transaction is abandoned and no response is produced. Reset wins over any simultaneous handshake.
- Valid fetch: request accepted at the end of cycle 0; rsp_valid high from cycle 4.
- Error fetch: rsp_valid high from cycle 1.
- Response handshake at the end of cycle n puts the FSM in IDLE for cycle n+1; the next request can be accepted in that same cycle. Peak throughput is one word per 5 cycles.
- req_valid asserted outside IDLE is ignored and is not latched.

## Structure
- Package rom_fetch_pkg holds:
  - the state enum (IDLE, SEL_LO, SEL_HI, CAP_HI, RESP);
  - WORD_BYTES=4;
  - a function computing the range/alignment error from address and MEMORY_SIZE.
- No sub-module. A single FSM plus datapath registers, instantiated alongside SimpleRom in the fetch stage.

## Test plan
ROM image bytes 0x00..0x07 = 3C 08 12 34 8D 09 00 04; MEMORY_SIZE=128; rsp_ready tied 1 unless stated.
- Fetch 0x0 → mem_sel/mem_sel_a = 0/1 in cycle 1 and 2/3 in cycle 2; rsp_data=0x3C081234, rsp_err=0, rsp_valid in cycle 4 for exactly one cycle.
- Back-to-back fetches 0x0 then 0x4 → 0x3C081234, then 0x8D090004 five cycles later; req_ready low during both transactions.
- Fetch 0x2 → rsp_err=1, rsp_data=0 in cycle 1; mem_sel and mem_sel_a unchanged. Fetch 0x7C → no error. Fetch 0x80 and 0xFFFFFFFC → rsp_err=1.
- rsp_ready low for 3 cycles in RESP → rsp_valid, rsp_data and rsp_err held; req_valid pulses during this time are ignored; handshake on the 4th cycle, then IDLE.
- rst asserted in SEL_HI → next cycle all outputs at reset values, no response ever emitted; a new fetch of 0x4 completes normally with 0x8D090004.

Source files
------------

// File: rtl/rom_word_fetcher_pkg.sv
// Shared types and helpers for the ROM word fetcher: FSM states, word geometry
// and the request address check.
package rom_fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEL_LO = 3'd1,
    ST_SEL_HI = 3'd2,
    ST_CAP_HI = 3'd3,
    ST_RESP   = 3'd4
  } fetch_state_e;

  // Addresses arrive zero-extended to 64 bits so addr+4 cannot wrap.
  function automatic logic fetch_err(input logic [63:0] addr, input logic [63:0] mem_size);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr + 64'(WORD_BYTES)) > mem_size);
    return misaligned | out_of_range;
  endfunction

endpackage

// File: rtl/rom_word_fetcher_if.sv
// Request, response and dual-port ROM select signals of the word fetcher.
// master is the fetcher's view; slave is the CPU front end plus ROM side.
interface rom_word_fetcher_if #(
  parameter int unsigned BUS_WIDTH    = 8,
  parameter int unsigned SELECT_WIDTH = 32
) ();
  import rom_fetch_pkg::*;

  localparam int unsigned WORD_W = WORD_BYTES * BUS_WIDTH;

  logic                    req_valid;
  logic [SELECT_WIDTH-1:0] req_addr;
  logic                    req_ready;
  logic                    rsp_valid;
  logic [WORD_W-1:0]       rsp_data;
  logic                    rsp_err;
  logic                    rsp_ready;
  logic [SELECT_WIDTH-1:0] mem_sel;
  logic [SELECT_WIDTH-1:0] mem_sel_a;
  logic [BUS_WIDTH-1:0]    mem_data;
  logic [BUS_WIDTH-1:0]    mem_data_a;

  modport master (
    input  req_valid, req_addr, rsp_ready, mem_data, mem_data_a,
    output req_ready, rsp_valid, rsp_data, rsp_err, mem_sel, mem_sel_a
  );

  modport slave (
    output req_valid, req_addr, rsp_ready, mem_data, mem_data_a,
    input  req_ready, rsp_valid, rsp_data, rsp_err, mem_sel, mem_sel_a
  );

endinterface

// File: rtl/rom_word_fetcher.sv
// Fetches a 32-bit big-endian word from a dual-port byte ROM, two bytes per
// cycle, and returns it over a valid/ready channel; bad addresses get an error.
module rom_word_fetcher
  import rom_fetch_pkg::*;
#(
  parameter int unsigned BUS_WIDTH    = 8,
  parameter int unsigned SELECT_WIDTH = 32,
  parameter int unsigned MEMORY_SIZE  = 128
) (
  input  logic               clk,
  input  logic               rst,
  rom_word_fetcher_if.master bus
);

  localparam int unsigned WORD_W = WORD_BYTES * BUS_WIDTH;

  fetch_state_e            r_state;
  fetch_state_e            w_state_nxt;
  logic [SELECT_WIDTH-1:0] r_addr;
  logic [SELECT_WIDTH-1:0] r_mem_sel;
  logic [SELECT_WIDTH-1:0] r_mem_sel_a;
  logic [WORD_W-1:0]       r_rsp_data;
  logic                    r_rsp_err;
  logic                    r_rsp_valid;
  logic                    w_req_ready;
  logic                    w_req_fire;
  logic                    w_addr_err;

  // Ready is gated by reset so a request is never taken while reset is held.
  assign w_req_ready = (r_state == ST_IDLE) & ~rst;
  assign w_req_fire  = bus.req_valid & w_req_ready;
  assign w_addr_err  = fetch_err(64'(bus.req_addr), 64'(MEMORY_SIZE));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_req_fire) w_state_nxt = w_addr_err ? ST_RESP : ST_SEL_LO;
      ST_SEL_LO: w_state_nxt = ST_SEL_HI;
      ST_SEL_HI: w_state_nxt = ST_CAP_HI;
      ST_CAP_HI: w_state_nxt = ST_RESP;
      ST_RESP:   if (bus.rsp_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Selects lead the captures by one cycle to cover the ROM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_mem_sel   <= '0;
      r_mem_sel_a <= '0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_addr <= bus.req_addr;
            if (w_addr_err) begin
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
              r_rsp_valid <= 1'b1;
            end else begin
              r_mem_sel   <= bus.req_addr;
              r_mem_sel_a <= bus.req_addr + SELECT_WIDTH'(1);
            end
          end
        end
        ST_SEL_LO: begin
          r_mem_sel   <= r_addr + SELECT_WIDTH'(2);
          r_mem_sel_a <= r_addr + SELECT_WIDTH'(3);
        end
        ST_SEL_HI: begin
          r_rsp_data[WORD_W-1 -: BUS_WIDTH]           <= bus.mem_data;
          r_rsp_data[WORD_W-BUS_WIDTH-1 -: BUS_WIDTH] <= bus.mem_data_a;
        end
        ST_CAP_HI: begin
          r_rsp_data[2*BUS_WIDTH-1 -: BUS_WIDTH] <= bus.mem_data;
          r_rsp_data[BUS_WIDTH-1 -: BUS_WIDTH]   <= bus.mem_data_a;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (bus.rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mem_sel   = r_mem_sel;
  assign bus.mem_sel_a = r_mem_sel_a;

endmodule

// File: tb/tb_rom_word_fetcher.sv
// Directed bench for rom_word_fetcher: table of fetches against a byte ROM
// model, plus hand sequences for select timing, back-pressure and reset.
module tb_rom_word_fetcher;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rom_word_fetcher_if #(.BUS_WIDTH(8), .SELECT_WIDTH(32)) bus_if ();

  rom_word_fetcher #(
    .BUS_WIDTH(8),
    .SELECT_WIDTH(32),
    .MEMORY_SIZE(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [128];

  // SimpleRom model: one-cycle registered read on both ports.
  always_ff @(posedge clk) begin
    bus_if.mem_data   <= rom[bus_if.mem_sel[6:0]];
    bus_if.mem_data_a <= rom[bus_if.mem_sel_a[6:0]];
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[8];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request in the current cycle and check the response; returns in
  // the cycle right after the response handshake (FSM back in IDLE).
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_lat);
    logic [31:0] sel0, sela0;
    logic        busy_ok;
    int          lat;
    check("ready_before_req", 64'(bus_if.req_ready), 64'd1);
    sel0  = bus_if.mem_sel;
    sela0 = bus_if.mem_sel_a;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = addr;
    step();
    bus_if.req_valid = 1'b0;
    lat = 1;
    if (exp_err) begin
      check("err_sel_held", 64'(bus_if.mem_sel), 64'(sel0));
      check("err_sel_a_held", 64'(bus_if.mem_sel_a), 64'(sela0));
    end
    busy_ok = 1'b1;
    while (!bus_if.rsp_valid && lat < 10) begin
      if (bus_if.req_ready) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (bus_if.req_ready) busy_ok = 1'b0;
    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("ready_low_busy", 64'(busy_ok), 64'd1);
    check("rsp_data", 64'(bus_if.rsp_data), 64'(exp_data));
    check("rsp_err", 64'(bus_if.rsp_err), 64'(exp_err));
    step();
    check("rsp_one_cycle", 64'(bus_if.rsp_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] held_data;
    logic        held_err;
    logic        seen;

    for (int i = 0; i < 128; i++) rom[i] = 8'(i);
    rom[0] = 8'h3C; rom[1] = 8'h08; rom[2] = 8'h12; rom[3] = 8'h34;
    rom[4] = 8'h8D; rom[5] = 8'h09; rom[6] = 8'h00; rom[7] = 8'h04;

    vecs[0] = '{addr: 32'h0000_0000, data: 32'h3C08_1234, err: 1'b0, lat: 4};
    vecs[1] = '{addr: 32'h0000_0004, data: 32'h8D09_0004, err: 1'b0, lat: 4};
    vecs[2] = '{addr: 32'h0000_0002, data: 32'h0000_0000, err: 1'b1, lat: 1};
    vecs[3] = '{addr: 32'h0000_007C, data: 32'h7C7D_7E7F, err: 1'b0, lat: 4};
    vecs[4] = '{addr: 32'h0000_0080, data: 32'h0000_0000, err: 1'b1, lat: 1};
    vecs[5] = '{addr: 32'hFFFF_FFFC, data: 32'h0000_0000, err: 1'b1, lat: 1};
    vecs[6] = '{addr: 32'h0000_0078, data: 32'h7879_7A7B, err: 1'b0, lat: 4};
    vecs[7] = '{addr: 32'h0000_0001, data: 32'h0000_0000, err: 1'b1, lat: 1};

    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.rsp_ready = 1'b1;

    // Reset state
    step();
    step();
    check("rst_req_ready", 64'(bus_if.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    check("rst_rsp_data", 64'(bus_if.rsp_data), 64'd0);
    check("rst_mem_sel", 64'(bus_if.mem_sel), 64'd0);
    rst = 1'b0;
    #1;
    check("idle_req_ready", 64'(bus_if.req_ready), 64'd1);

    // Select timing of a single fetch of 0x0
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 32'h0;
    step();
    bus_if.req_valid = 1'b0;
    check("c1_mem_sel", 64'(bus_if.mem_sel), 64'd0);
    check("c1_mem_sel_a", 64'(bus_if.mem_sel_a), 64'd1);
    step();
    check("c2_mem_sel", 64'(bus_if.mem_sel), 64'd2);
    check("c2_mem_sel_a", 64'(bus_if.mem_sel_a), 64'd3);
    step();
    check("c3_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    step();
    check("c4_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
    check("c4_rsp_data", 64'(bus_if.rsp_data), 64'h3C08_1234);
    step();
    check("c5_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);

    // Table: back-to-back fetches, each issued in the cycle after the last handshake
    for (int i = 0; i < 8; i++)
      do_fetch(vecs[i].addr, vecs[i].data, vecs[i].err, vecs[i].lat);

    // Back-pressure: response held while rsp_ready low, stray requests ignored
    bus_if.rsp_ready = 1'b0;
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 32'h4;
    step();
    bus_if.req_valid = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("bp_rsp_valid", 64'(bus_if.rsp_valid), 64'd1);
    held_data = bus_if.rsp_data;
    held_err  = bus_if.rsp_err;
    check("bp_rsp_data", 64'(held_data), 64'h8D09_0004);
    for (int c = 0; c < 3; c++) begin
      bus_if.req_valid = 1'b1;
      bus_if.req_addr  = 32'h2;
      step();
      check("bp_valid_held", 64'(bus_if.rsp_valid), 64'd1);
      check("bp_data_held", 64'(bus_if.rsp_data), 64'(held_data));
      check("bp_err_held", 64'(bus_if.rsp_err), 64'(held_err));
      check("bp_ready_low", 64'(bus_if.req_ready), 64'd0);
    end
    bus_if.req_valid = 1'b0;
    bus_if.rsp_ready = 1'b1;
    step();
    check("bp_done_valid", 64'(bus_if.rsp_valid), 64'd0);
    check("bp_done_idle", 64'(bus_if.req_ready), 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus_if.rsp_valid) seen = 1'b1;
    end
    check("bp_no_stray_rsp", 64'(seen), 64'd0);

    // Reset while in SEL_HI abandons the fetch
    bus_if.req_valid = 1'b1;
    bus_if.req_addr  = 32'h0;
    step();
    bus_if.req_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("mid_rst_rsp_valid", 64'(bus_if.rsp_valid), 64'd0);
    check("mid_rst_rsp_err", 64'(bus_if.rsp_err), 64'd0);
    check("mid_rst_rsp_data", 64'(bus_if.rsp_data), 64'd0);
    check("mid_rst_mem_sel", 64'(bus_if.mem_sel), 64'd0);
    check("mid_rst_mem_sel_a", 64'(bus_if.mem_sel_a), 64'd0);
    check("mid_rst_req_ready", 64'(bus_if.req_ready), 64'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus_if.rsp_valid) seen = 1'b1;
    end
    check("mid_rst_no_rsp", 64'(seen), 64'd0);
    do_fetch(32'h4, 32'h8D09_0004, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
